// File: rtl/mem_hs_initiator.sv
// Sequences a write / read-back pattern test over a memory window on a valid/ready front door.
// Registered outputs; one transfer per cycle with ready high, a stall holds the request stable until accepted or timed out.
module mem_hs_initiator #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   num_loc_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d, mode_eff;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         num_q, num_d, num_clamp;
    logic [WIDTH-1:0]      seed_q, seed_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         stall_q, stall_d;

    logic [ADDR_WIDTH-1:0] addr_d, first_d, next_addr;
    logic [WIDTH-1:0]      wdata_d;
    logic                  wr_rd_d, valid_d, busy_d, done_d, pass_d, timeout_d;
    logic [CW-1:0]         err_d;
    logic                  fire, mismatch, finish;

    assign fire      = valid_o && ready_i;
    assign mismatch  = (state_q == S_READ) && fire && (rdata_i != (seed_q ^ WIDTH'(addr_o)));
    assign next_addr = addr_o + ADDR_WIDTH'(1);
    assign mode_eff  = (mode_i == 2'b11) ? 2'b00 : mode_i;
    assign num_clamp = (num_loc_i > CW'(DEPTH)) ? CW'(DEPTH) : num_loc_i;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        base_d    = base_q;
        num_d     = num_q;
        seed_d    = seed_q;
        idx_d     = idx_q;
        stall_d   = stall_q;
        addr_d    = addr_o;
        wdata_d   = wdata_o;
        wr_rd_d   = wr_rd_o;
        valid_d   = valid_o;
        busy_d    = busy_o;
        done_d    = 1'b0;
        pass_d    = pass_o;
        timeout_d = timeout_o;
        err_d     = err_count_o;
        first_d   = first_err_addr_o;
        finish    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE behaves like IDLE so a start in the done_o cycle is taken.
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                wr_rd_d = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                if (start_i) begin
                    mode_d    = mode_eff;
                    base_d    = start_addr_i;
                    num_d     = num_clamp;
                    seed_d    = seed_i;
                    idx_d     = '0;
                    stall_d   = '0;
                    err_d     = '0;
                    first_d   = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    if (num_clamp == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        valid_d = 1'b1;
                        addr_d  = start_addr_i;
                        if (mode_eff == 2'b10) begin
                            state_d = S_READ;
                        end else begin
                            state_d = S_WRITE;
                            wr_rd_d = 1'b1;
                            wdata_d = seed_i ^ WIDTH'(start_addr_i);
                        end
                    end
                end
            end
            S_GAP: begin
                state_d = S_READ;
                valid_d = 1'b1;
                wr_rd_d = 1'b0;
                addr_d  = base_q;
                wdata_d = '0;
                idx_d   = '0;
            end
            S_WRITE, S_READ: begin
                if (fire) begin
                    stall_d = '0;
                    idx_d   = idx_q + CW'(1);
                    if (mismatch) begin
                        if (err_count_o == '0)
                            first_d = addr_o;
                        if (err_count_o != '1)
                            err_d = err_count_o + CW'(1);
                    end
                    if (idx_q + CW'(1) == num_q) begin
                        if (state_q == S_WRITE && mode_q == 2'b00) begin
                            state_d = S_GAP;
                            valid_d = 1'b0;
                            wr_rd_d = 1'b0;
                            addr_d  = '0;
                            wdata_d = '0;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        addr_d  = next_addr;
                        wdata_d = (state_q == S_WRITE) ? (seed_q ^ WIDTH'(next_addr)) : '0;
                    end
                end else if (stall_q == TW'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            wr_rd_d = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            pass_d  = (err_d == '0) && !timeout_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            mode_q           <= '0;
            base_q           <= '0;
            num_q            <= '0;
            seed_q           <= '0;
            idx_q            <= '0;
            stall_q          <= '0;
            addr_o           <= '0;
            wdata_o          <= '0;
            wr_rd_o          <= 1'b0;
            valid_o          <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
        end else begin
            state_q          <= state_d;
            mode_q           <= mode_d;
            base_q           <= base_d;
            num_q            <= num_d;
            seed_q           <= seed_d;
            idx_q            <= idx_d;
            stall_q          <= stall_d;
            addr_o           <= addr_d;
            wdata_o          <= wdata_d;
            wr_rd_o          <= wr_rd_d;
            valid_o          <= valid_d;
            busy_o           <= busy_d;
            done_o           <= done_d;
            pass_o           <= pass_d;
            timeout_o        <= timeout_d;
            err_count_o      <= err_d;
            first_err_addr_o <= first_d;
        end
    end
endmodule

// File: tb/tb_mem_hs_initiator.sv
// Scoreboard bench for mem_hs_initiator: expected transfers queued per run, popped at each handshake.
module tb_mem_hs_initiator;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  mode_i = '0;
    logic [3:0]  start_addr_i = '0;
    logic [4:0]  num_loc_i = '0;
    logic [15:0] seed_i = '0;
    logic [3:0]  addr_o;
    logic [15:0] wdata_o;
    logic        wr_rd_o, valid_o, busy_o, done_o, pass_o, timeout_o;
    logic        ready_i = 1'b1;
    logic [15:0] rdata_i;
    logic [4:0]  err_count_o;
    logic [3:0]  first_err_addr_o;

    mem_hs_initiator #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .start_addr_i(start_addr_i), .num_loc_i(num_loc_i), .seed_i(seed_i),
        .addr_o(addr_o), .wdata_o(wdata_o), .wr_rd_o(wr_rd_o), .valid_o(valid_o),
        .ready_i(ready_i), .rdata_i(rdata_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
        .first_err_addr_o(first_err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] dat;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [15:0] mem [16];
    int          n_chk = 0;
    int          n_err = 0;
    int          rmode = 0;
    logic        flip_en = 1'b0;
    logic [3:0]  flip_addr = '0;
    int          rd_pres = 0;
    logic        prev_stall = 1'b0;
    logic [3:0]  prev_addr;
    logic [15:0] prev_wdata;

    assign rdata_i = mem[addr_o] ^ {15'd0, (flip_en && addr_o == flip_addr)};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Memory model / scoreboard consumer, sampled mid-cycle.
    always @(negedge clk_i) begin
        xfer_t x;
        if (prev_stall && !done_o && !rst_i) begin
            chk("stall_vld", {31'd0, valid_o}, 32'd1);
            chk("stall_addr", {28'd0, addr_o}, {28'd0, prev_addr});
            chk("stall_wdata", {16'd0, wdata_o}, {16'd0, prev_wdata});
        end
        prev_stall = valid_o && !ready_i;
        prev_addr  = addr_o;
        prev_wdata = wdata_o;
        if (valid_o && !wr_rd_o) rd_pres++;
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexp_xfer", {28'd0, addr_o}, 32'hFFFF_FFFF);
            end else begin
                x = exp_q.pop_front();
                chk("xfer_wr", {31'd0, wr_rd_o}, {31'd0, x.wr});
                chk("xfer_addr", {28'd0, addr_o}, {28'd0, x.addr});
                if (x.wr) chk("xfer_wdata", {16'd0, wdata_o}, {16'd0, x.dat});
            end
            if (wr_rd_o) mem[addr_o] = wdata_o;
        end
    end

    // Ready generator: 0 ideal, 1 three stall cycles per transfer, 2 stuck low.
    initial begin
        int sc;
        sc = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rmode == 0) ready_i = 1'b1;
            else if (rmode == 2) ready_i = 1'b0;
            else if (!valid_o) begin ready_i = 1'b0; sc = 0; end
            else if (sc < 3) begin ready_i = 1'b0; sc++; end
            else begin ready_i = 1'b1; sc = 0; end
        end
    end

    task automatic run(input string tag, input logic [1:0] md, input logic [3:0] sa,
                       input logic [4:0] num, input logic [15:0] seed, input int rm,
                       input logic xfers, input logic poke, input int exp_cyc,
                       input logic exp_pass, input logic [4:0] exp_err,
                       input logic [3:0] exp_first, input logic exp_to);
        int n, k, rd0;
        logic got;
        logic [1:0] me;
        logic [3:0] a;
        me = (md == 2'b11) ? 2'b00 : md;
        n  = (num > 5'd16) ? 16 : int'(num);
        if (xfers) begin
            if (me != 2'b10)
                for (int i = 0; i < n; i++) begin
                    a = sa + 4'(i);
                    exp_q.push_back('{1'b1, a, seed ^ {12'd0, a}});
                end
            if (me != 2'b01)
                for (int i = 0; i < n; i++) begin
                    a = sa + 4'(i);
                    exp_q.push_back('{1'b0, a, 16'd0});
                end
        end
        @(posedge clk_i);
        #1;
        rmode = rm; mode_i = md; start_addr_i = sa; num_loc_i = num; seed_i = seed; start_i = 1'b1;
        rd0 = rd_pres;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        k = 1;
        got = 1'b0;
        while (!got && k <= 200) begin
            @(negedge clk_i);
            if (done_o) got = 1'b1;
            else begin
                if (poke && k == 2) begin
                    start_i = 1'b1; mode_i = 2'b10; num_loc_i = 5'd1;
                end
                if (k == 3) start_i = 1'b0;
                @(posedge clk_i);
                #1;
                k++;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk({tag, "_done_cyc"}, k, exp_cyc);
            chk({tag, "_pass"}, {31'd0, pass_o}, {31'd0, exp_pass});
            chk({tag, "_errcnt"}, {27'd0, err_count_o}, {27'd0, exp_err});
            chk({tag, "_first"}, {28'd0, first_err_addr_o}, {28'd0, exp_first});
            chk({tag, "_timeout"}, {31'd0, timeout_o}, {31'd0, exp_to});
            chk({tag, "_busy_done"}, {31'd0, busy_o}, 32'd0);
            if (exp_to) chk({tag, "_no_read"}, rd_pres - rd0, 0);
        end
        @(negedge clk_i);
        chk({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_idle_vld"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int vld0;
        logic saw_done;
        // Reset with start held high: must be ignored.
        start_i = 1'b1; mode_i = 2'b00; num_loc_i = 5'd4; seed_i = 16'h1234;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_outs", {addr_o, wdata_o, wr_rd_o, valid_o, busy_o, done_o, pass_o, timeout_o},
            32'd0);
        chk("rst_errs", {23'd0, err_count_o, first_err_addr_o}, 32'd0);
        start_i = 1'b0; rst_i = 1'b0;

        run("pass",   2'b00, 4'd0,  5'd4,  16'hA5A0, 0, 1'b1, 1'b0, 10, 1'b1, 5'd0, 4'd0, 1'b0);
        run("wrap",   2'b00, 4'd14, 5'd4,  16'h0000, 0, 1'b1, 1'b0, 10, 1'b1, 5'd0, 4'd0, 1'b0);
        run("vfy",    2'b10, 4'd14, 5'd4,  16'h0000, 0, 1'b1, 1'b0, 5,  1'b1, 5'd0, 4'd0, 1'b0);
        flip_en = 1'b1; flip_addr = 4'd2;
        run("inj",    2'b00, 4'd0,  5'd4,  16'hA5A0, 0, 1'b1, 1'b0, 10, 1'b0, 5'd1, 4'd2, 1'b0);
        flip_en = 1'b0;
        run("wo",     2'b01, 4'd5,  5'd3,  16'h0F0F, 0, 1'b1, 1'b0, 4,  1'b1, 5'd0, 4'd0, 1'b0);
        run("stall",  2'b00, 4'd0,  5'd4,  16'hA5A0, 1, 1'b1, 1'b0, 34, 1'b1, 5'd0, 4'd0, 1'b0);
        run("tmo",    2'b00, 4'd0,  5'd4,  16'hA5A0, 2, 1'b0, 1'b0, 17, 1'b0, 5'd0, 4'd0, 1'b1);
        vld0 = rd_pres;
        run("zero",   2'b00, 4'd3,  5'd0,  16'h7777, 0, 1'b0, 1'b0, 1,  1'b1, 5'd0, 4'd0, 1'b0);
        run("clampw", 2'b01, 4'd0,  5'd20, 16'h3C00, 0, 1'b1, 1'b0, 17, 1'b1, 5'd0, 4'd0, 1'b0);
        run("clampv", 2'b10, 4'd0,  5'd20, 16'h3C00, 0, 1'b1, 1'b0, 17, 1'b1, 5'd0, 4'd0, 1'b0);
        run("mode3",  2'b11, 4'd9,  5'd2,  16'hBEEF, 0, 1'b1, 1'b0, 6,  1'b1, 5'd0, 4'd0, 1'b0);
        run("busy",   2'b01, 4'd8,  5'd4,  16'h1111, 0, 1'b1, 1'b1, 5,  1'b1, 5'd0, 4'd0, 1'b0);
        chk("zero_no_read", rd_pres - vld0 >= 0, 1);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b1, 4'(i), 16'h0005 ^ 16'(i)});
        @(posedge clk_i);
        #1;
        mode_i = 2'b01; start_addr_i = 4'd0; num_loc_i = 5'd8; seed_i = 16'h0005; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_vld_pre", {31'd0, valid_o}, 32'd1);
        @(negedge clk_i);
        chk("midrst_vld", {31'd0, valid_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (done_o || valid_o) saw_done = 1'b1;
        end
        chk("midrst_no_done", {31'd0, saw_done}, 32'd0);
        chk("midrst_q", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
